mem_wb_pipe: RTL
================

Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage register for the 5-stage CPU, sitting between data-memory access and register-file writeback.
- Generalises the plain MEM/WB latch: configurable data and register-address widths, valid/ready handshake with a 2-entry skid buffer, flush, and bubble-safe writeback control decode.
- Also drives the selected writeback data so the register file and the forwarding unit use one source.

Parameters:
- DATA_W, 32, width of the memory read data, ALU result and writeback data.
- ADDR_W, 5, width of the destination register address.
- ZERO_REG_SUPPRESS, 1, when 1, forces RegWrite_o to 0 if the destination address is 0.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  discards all held entries and the incoming one.
- valid_i  in  1  MEM stage presents an instruction.
- ready_o  out  1  stage can accept an instruction this cycle.
- WB_i  in  2  writeback control: [1]=RegWrite, [0]=MemToReg.
- ReadData_i  in  DATA_W  data-memory read data.
- MUX3_i  in  DATA_W  ALU result from EX/MEM.
- addr_i  in  ADDR_W  destination register.
- valid_o  out  1  output entry is valid.
- ready_i  in  1  WB consumer accepts the entry.
- RegWrite_o  out  1  gated register-write enable.
- MemToReg_o  out  1  gated writeback-select.
- ReadData_o  out  DATA_W  held read data.
- MUX3_o  out  DATA_W  held ALU result.
- addr_o  out  ADDR_W  held destination register.
- WBData_o  out  DATA_W  MemToReg_o ? ReadData_o : MUX3_o.

Behaviour:
- Storage: main entry (drives the outputs) and skid entry. Each entry has its own valid bit.
- Accept: accept = valid_i & ready_o & !flush_i.
- Output transfer: out_xfer = valid_o & ready_i.
- ready_o is the registered value of !skid_valid. It has no combinational path from ready_i.
- Latency: an accepted entry appears on the outputs on the next cycle, provided the main entry is empty or is transferring out that cycle.
- Edge update, in priority order:
  - rst_i: main_valid=0, skid_valid=0, all data/addr/WB registers=0.
  - else flush_i: main_valid=0, skid_valid=0. Data registers may hold their values.
  - else, with out_xfer and skid_valid: main<=skid. Then skid<=input if accept, else skid_valid=0.
  - else, with out_xfer and no skid: main<=input if accept, else main_valid=0.
  - else, with no out_xfer: if main is empty and accept, main<=input. If main is valid and accept, skid<=input.
- An accept with both entries full cannot happen, because ready_o=0 in that state.
- Ordering: entries leave strictly in arrival order. No drop and no duplication.
- Control decode. Outputs are defined 0 for a bubble, never X:
  - RegWrite_o = valid_o & WB[1] & !(ZERO_REG_SUPPRESS & addr_o==0).
  - MemToReg_o = valid_o & WB[1] & WB[0].
  - WB=2'b10 is an R-type write, 2'b11 is a load, 2'b00 or 2'b01 is a bubble or store.
- Reset values: valid_o=0, ready_o=1 on the first cycle after reset, RegWrite_o=0, MemToReg_o=0. ReadData_o, MUX3_o, addr_o and WBData_o are 0.
- Simultaneous flush_i and valid_i: the input is dropped and ready_o=1 on the next cycle.
- Reset has priority over flush. Reset mid-stall empties both entries.
- A valid entry holds all its outputs stable until out_xfer.

Test Plan:
- Reset: assert rst_i for 2 cycles while valid_i=1. Required: valid_o=0, RegWrite_o=0, ready_o=1, all data outputs 0.
- Streaming with ready_i=1: send a load (WB=11, ReadData=0xDEADBEEF, MUX3=0x10, addr=8), then an R-type (WB=10, MUX3=0x5, addr=9) on consecutive cycles. Required: 1-cycle latency; WBData_o is 0xDEADBEEF with MemToReg_o=1, then 0x5 with MemToReg_o=0; RegWrite_o=1 for both.
- Back-pressure: hold ready_i=0, send A, B, C. Required: A in main, B in skid; ready_o drops the cycle after B is accepted; C is held at the source. Release ready_i: A, B, C appear in order with no loss.
- Bubble and $0 write: WB=00 gives RegWrite_o=0 and MemToReg_o=0 with valid_o=1. WB=10 with addr=0 and ZERO_REG_SUPPRESS=1 gives RegWrite_o=0.
- Flush with both entries full plus a new input: required valid_o=0 and ready_o=1 on the next cycle, and the new input never appears on the outputs.
- Reset asserted while stalled with skid full: both entries are emptied and the outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage with valid/ready handshake, 2-entry skid buffer, flush and
// bubble-safe writeback control decode; also selects the writeback data.
module mem_wb_pipe #(
  parameter int DATA_W            = 32,
  parameter int ADDR_W            = 5,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] MUX3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] MUX3_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] WBData_o
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] mux;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t main_ent_q, main_ent_d;
  entry_t skid_ent_q, skid_ent_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;

  entry_t in_ent;
  logic   accept;
  logic   out_xfer;

  always_comb begin
    in_ent       = '{wb: WB_i, rd: ReadData_i, mux: MUX3_i, addr: addr_i};
    accept       = valid_i & ready_q & ~flush_i;
    out_xfer     = main_valid_q & ready_i;
    main_ent_d   = main_ent_q;
    skid_ent_d   = skid_ent_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        // The skid entry is older than anything arriving now, so it moves up first.
        main_ent_d   = skid_ent_q;
        main_valid_d = 1'b1;
        if (accept) begin
          skid_ent_d   = in_ent;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_ent_d   = in_ent;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_ent_d   = in_ent;
        main_valid_d = 1'b1;
      end else begin
        skid_ent_d   = in_ent;
        skid_valid_d = 1'b1;
      end
    end

    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_ent_q   <= '0;
      skid_ent_q   <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_ent_q   <= main_ent_d;
      skid_ent_q   <= skid_ent_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  // Control is gated by valid so a bubble can never trigger a register write.
  assign ready_o    = ready_q;
  assign valid_o    = main_valid_q;
  assign RegWrite_o = main_valid_q & main_ent_q.wb[1]
                      & ~((ZERO_REG_SUPPRESS != 0) && (main_ent_q.addr == '0));
  assign MemToReg_o = main_valid_q & main_ent_q.wb[1] & main_ent_q.wb[0];
  assign ReadData_o = main_ent_q.rd;
  assign MUX3_o     = main_ent_q.mux;
  assign addr_o     = main_ent_q.addr;
  assign WBData_o   = MemToReg_o ? main_ent_q.rd : main_ent_q.mux;

endmodule
